// File: rtl/commit_trace_collector.sv
// commit_trace_collector
// Turns CPU commit-bus events into a buffered record stream (valid/ready),
// and on a halt walks the register file through the debug read port to
// emit a 32-entry register dump. Requests a CPU hold before the FIFO overflows.
// Optional feature macro: TRACE_DUMP_EN (register dump after halt).
// Without it, a halt goes straight to DONE and debug_reg_ra stays 0.
module commit_trace_collector #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  output logic [4:0]  debug_reg_ra,
  input  logic [31:0] debug_reg_rd,
  input  logic        restart,
  output logic        hold_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_type,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        done,
  output logic        overflow,
  output logic        conflict,
  output logic [15:0] drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HOLD = CW'(DEPTH - 2);

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_DUMP    = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [1:0] T_REG  = 2'd0;
  localparam logic [1:0] T_MEM  = 2'd1;
  localparam logic [1:0] T_DUMP = 2'd2;
  localparam logic [1:0] T_HALT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   retired_q, retired_d;
  logic [4:0]    idx_q, idx_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic          conflict_q, conflict_d;
  logic          done_q, done_d;

  // record = {type[1:0], addr[31:0], data[31:0]}
  logic [65:0]   mem_q [DEPTH];
  logic [65:0]   head_rec;
  logic [65:0]   push_rec;
  logic [31:0]   retired_inc;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          room;

`ifndef TRACE_DUMP_EN
  logic unused_rd;
  assign unused_rd = ^debug_reg_rd;
`endif

  assign retired_inc = retired_q + 32'd1;
  assign pop         = (count_q != '0) && out_ready;
  // a pop on the same edge frees the slot the push needs
  assign room        = (count_q != CNT_FULL) || pop;

  // Next-state, record selection and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    idx_d      = idx_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    conflict_d = conflict_q;
    done_d     = done_q;
    push_req   = 1'b0;
    push_rec   = '0;

    case (state_q)
      ST_CAPTURE: begin
        if (commit) begin
          retired_d = retired_inc;
          if (commit_reg_we && commit_dmem_we) conflict_d = 1'b1;
          if (commit_halt) begin
            push_req = 1'b1;
            push_rec = {T_HALT, commit_pc, retired_inc};
`ifdef TRACE_DUMP_EN
            state_d  = ST_DUMP;
`else
            state_d  = ST_DONE;
            done_d   = 1'b1;
`endif
          end else if (commit_reg_we && (commit_reg_wa != 5'd0)) begin
            push_req = 1'b1;
            push_rec = {T_REG, 27'd0, commit_reg_wa, commit_reg_wd};
          end else if (commit_dmem_we) begin
            push_req = 1'b1;
            push_rec = {T_MEM, commit_dmem_wa, commit_dmem_wd};
          end
          if (push_req && !room) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      ST_DUMP: begin
`ifdef TRACE_DUMP_EN
        // dump stalls rather than drops when the FIFO is full
        push_req = 1'b1;
        push_rec = {T_DUMP, 27'd0, idx_q, debug_reg_rd};
        if (room) begin
          if (idx_q == 5'd31) begin
            idx_d   = '0;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
`else
        state_d = ST_DONE;
        done_d  = 1'b1;
`endif
      end
      ST_DONE: begin
        if (restart) begin
          state_d   = ST_CAPTURE;
          retired_d = '0;
          done_d    = 1'b0;
        end
      end
      default: state_d = ST_CAPTURE;
    endcase

    push_ok  = push_req && room;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CAPTURE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      retired_q  <= '0;
      idx_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      retired_q  <= retired_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      conflict_q <= conflict_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by out_valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_rec;
  end

  assign head_rec     = mem_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign out_type     = out_valid ? head_rec[65:64] : '0;
  assign out_addr     = out_valid ? head_rec[63:32] : '0;
  assign out_data     = out_valid ? head_rec[31:0]  : '0;
  assign hold_req     = (count_q >= CNT_HOLD) || (state_q != ST_CAPTURE);
  assign debug_reg_ra = idx_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign conflict     = conflict_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/commit_trace_collector.md
# commit_trace_collector

- Consumes the single-cycle CPU's commit debug bus and its register-file debug read port.
- Turns architectural events into a buffered record stream for a host-side drain (UART bridge or testbench) over a valid/ready handshake.
- When a halt commits, it walks `debug_reg_ra` over x0..x31 and emits a full register dump.
- It asserts a hold request so the top level can deassert the CPU's `global_en` before records are lost.

## Interface
- `DEPTH`, 16: record FIFO entries; power of two, at least 4.
- `clk`  in  1  system clock, shared with the CPU.
- `rst_n`  in  1  asynchronous active-low reset.
- `commit`, `commit_pc`, `commit_halt`, `commit_reg_we`, `commit_reg_wa`, `commit_reg_wd`, `commit_dmem_we`, `commit_dmem_wa`, `commit_dmem_wd`  in  1/32/1/1/5/32/1/32/32  the CPU commit bus, registered at the CPU.
- `debug_reg_ra`  out  5  register index driven to the CPU.
- `debug_reg_rd`  in  32  register value; combinational from `debug_reg_ra`.
- `restart`  in  1  one-cycle pulse; leaves DONE.
- `hold_req`  out  1  request to drop CPU `global_en`.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  host accepts the record.
- `out_type`  out  2  0 REG, 1 MEM, 2 DUMP, 3 HALT.
- `out_addr`  out  32  REG: {27'b0,wa}; MEM: dmem_wa; DUMP: {27'b0,index}; HALT: commit_pc.
- `out_data`  out  32  REG: wd; MEM: dmem_wd; DUMP: register value; HALT: retired count.
- `done`  out  1  dump complete, collector idle.
- `overflow`  out  1  sticky; a record was dropped.
- `conflict`  out  1  sticky; reg_we and dmem_we were high on the same commit.
- `drop_cnt`  out  16  dropped records, saturating at 16'hFFFF.

## Operation
- **States:** CAPTURE, DUMP, DONE. Reset enters CAPTURE.
- **CAPTURE, per cycle with `commit`=1:**
  - Retired counter (32-bit, wraps) increments.
  - If `commit_halt`, push a HALT record. Its data is the count including this commit. Go to DUMP.
  - Else if `commit_reg_we` and wa≠0, push a REG record.
  - Else if `commit_dmem_we`, push a MEM record.
  - reg_we=1 with wa=0 produces no record.
  - reg_we and dmem_we both high: push the REG record only, set `conflict`.
- **Push acceptance:** a push is accepted if FIFO count<DEPTH, or if a pop occurs the same cycle. Otherwise the record is dropped, `drop_cnt`++ and `overflow` is set. A dropped HALT still transitions to DUMP.
- **DUMP:**
  - `debug_reg_ra` starts at 0.
  - Each cycle in which a push is accepted: push a DUMP record {index, `debug_reg_rd`}, then index++.
  - When the FIFO is full, stall without dropping.
  - After index 31 is pushed, go to DONE.
  - Commits arriving in DUMP are ignored and not counted.
- **DONE:**
  - `done`=1. Commits are ignored.
  - `restart` clears the retired counter and `done` and returns to CAPTURE.
  - FIFO contents, sticky flags and `drop_cnt` are kept.
- **FIFO:** first-word-fall-through. A pop happens when `out_valid && out_ready`. Pointers wrap modulo DEPTH; count is held in log2(DEPTH)+1 bits.
- **hold_req:** 1 when count ≥ DEPTH-2, or when the state is DUMP/DONE. The CPU commit stage adds one cycle of delay, so two free slots cover the in-flight commit.

## Timing
- **Reset values (async, rst_n=0):**
  - state CAPTURE; FIFO empty.
  - `out_valid`, `hold_req`, `done`, `overflow`, `conflict` = 0.
  - `debug_reg_ra`, `drop_cnt`, retired counter, `out_*` = 0.
- A commit sampled at edge N is visible on `out_valid` after edge N, i.e. 1-cycle latency into an empty FIFO.
- `out_type`/`out_addr`/`out_data` stay stable while `out_valid`=1 and `out_ready`=0.
- **DUMP timing:**
  - The first DUMP push occurs on the edge after the HALT push.
  - Throughput is one record per cycle when not full.
  - `debug_reg_ra` is registered; data is sampled at the same edge that advances it.
- `restart` is honoured only in DONE and ignored elsewhere.
- `done` rises on the edge that pushes index 31.
- Reset mid-DUMP: everything returns to reset values immediately, and the FIFO is discarded.

## Configuration
- **`TRACE_DUMP_EN`:**
  - Defined: DUMP behaves as above.
  - Undefined: HALT goes straight to DONE, DUMP records are never produced, and `debug_reg_ra` is held at 0.

## Test plan
- **Register write:** addi writes x5=32'h0000_0007, out_ready=1 → one record type0, addr 5, data 7, out_valid for exactly 1 cycle.
- **Store and x0 write:** sw of 32'hDEAD_BEEF to 32'h0000_0100, then a commit with wa=0 → one MEM record addr 32'h100, data 32'hDEADBEEF; nothing for the x0 write.
- **Backpressure:** out_ready=0 with 20 back-to-back REG commits, DEPTH=16 → hold_req rises when count hits 14; records 17..20 dropped; drop_cnt=4; overflow=1; the first 16 drain in order once ready=1.
- **Halt and dump:** halt at pc 32'h0000_0040 as the 10th commit → HALT record addr 32'h40, data 10, followed by 32 DUMP records with indices 0..31 matching the RF model; done=1.
- **Dump under stall:** out_ready toggling every cycle during DUMP → no DUMP record lost; indices contiguous.
- **Async reset mid-DUMP:** rst_n low at dump index 12 → all outputs zero within the same cycle; after release, a new commit produces a normal record.
